// File: rtl/pcie_rq_np_gate.sv
// Requester-request flow-control gate: admits non-posted TLPs only with sufficient NP credit
// and after a hold-off window, passes packets atomically, and registers the output through a 2-entry skid buffer.
module pcie_rq_np_gate #(
  parameter int MIN_NPH = 2,
  parameter int MIN_NPD = 2,
  parameter int HOLDOFF = 4
) (
  input  logic         pcie_clk,
  input  logic         pcie_reset,
  input  logic [255:0] in_rq_tdata,
  input  logic [59:0]  in_rq_tuser,
  input  logic [7:0]   in_rq_tkeep,
  input  logic         in_rq_tlast,
  input  logic         in_rq_tvalid,
  output logic         in_rq_tready,
  output logic [255:0] out_rq_tdata,
  output logic [59:0]  out_rq_tuser,
  output logic [7:0]   out_rq_tkeep,
  output logic         out_rq_tlast,
  output logic         out_rq_tvalid,
  input  logic         out_rq_tready,
  input  logic [1:0]   pcie_tfc_nph_av,
  input  logic [1:0]   pcie_tfc_npd_av,
  input  logic         stat_clear,
  output logic [31:0]  stat_np_pkts,
  output logic [31:0]  stat_p_pkts,
  output logic [31:0]  stat_gate_cycles
);

  localparam int BW = 325;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PASS = 1'b1} state_t;

  function automatic logic is_posted(input logic [3:0] t);
    return (t == 4'b0001) || (t[3:2] == 2'b11);
  endfunction

  function automatic logic needs_npd(input logic [3:0] t);
    logic r;
    case (t)
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1010, 4'b1011: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [1:0]      count_r, count_nxt_s;
  logic            full_r;
  logic            out_valid_r;
  logic [3:0]      holdoff_r;
  logic [BW-1:0]   head_r, tail_r;
  logic [BW-1:0]   in_beat_s;
  logic [3:0]      req_type_s;
  logic            sop_posted_s, gate_open_s, in_ready_s;
  logic            push_s, pop_s, sop_accept_s, np_sop_accept_s, gate_block_s;
  logic [31:0]     np_pkts_r, p_pkts_r, gate_cycles_r;

  assign req_type_s   = in_rq_tdata[78:75];
  assign sop_posted_s = is_posted(req_type_s);
  assign in_beat_s    = {in_rq_tdata, in_rq_tuser, in_rq_tkeep, in_rq_tlast};

  // Admission gate for an SOP presented in IDLE
  always_comb begin
    gate_open_s = 1'b0;
    if (sop_posted_s) begin
      gate_open_s = 1'b1;
    end else if (({1'b0, pcie_tfc_nph_av} >= 3'(MIN_NPH)) && (holdoff_r == 4'd0) &&
                 (!needs_npd(req_type_s) || ({1'b0, pcie_tfc_npd_av} >= 3'(MIN_NPD)))) begin
      gate_open_s = 1'b1;
    end else begin
      gate_open_s = 1'b0;
    end
  end

  // Ready never depends on the downstream ready, only on the registered full flag
  assign in_ready_s      = ~full_r & ~pcie_reset & ((state_r == ST_PASS) | gate_open_s);
  assign push_s          = in_rq_tvalid & in_ready_s;
  assign pop_s           = out_valid_r & out_rq_tready;
  assign sop_accept_s    = push_s & (state_r == ST_IDLE);
  assign np_sop_accept_s = sop_accept_s & ~sop_posted_s;
  assign gate_block_s    = (state_r == ST_IDLE) & in_rq_tvalid & ~sop_posted_s & ~full_r & ~gate_open_s;

  // Packet-atomic control FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s && !in_rq_tlast) state_nxt_s = ST_PASS;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_PASS: begin
        if (push_s && in_rq_tlast) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_PASS;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Skid buffer occupancy next value
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FSM state register
  always_ff @(posedge pcie_clk) begin
    if (pcie_reset) state_r <= ST_IDLE;
    else            state_r <= state_nxt_s;
  end

  // Skid buffer storage; head entry drives the outputs directly
  always_ff @(posedge pcie_clk) begin
    if (pcie_reset) begin
      count_r     <= 2'd0;
      full_r      <= 1'b0;
      out_valid_r <= 1'b0;
      head_r      <= '0;
      tail_r      <= '0;
    end else begin
      count_r     <= count_nxt_s;
      full_r      <= (count_nxt_s == 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) head_r <= in_beat_s;
          else                 tail_r <= in_beat_s;
        end
        2'b01: head_r <= tail_r;
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= in_beat_s;
          end else begin
            head_r <= tail_r;
            tail_r <= in_beat_s;
          end
        end
        default: begin
          head_r <= head_r;
          tail_r <= tail_r;
        end
      endcase
    end
  end

  // NP hold-off window counter
  always_ff @(posedge pcie_clk) begin
    if (pcie_reset)             holdoff_r <= 4'd0;
    else if (np_sop_accept_s)   holdoff_r <= 4'(HOLDOFF);
    else if (holdoff_r != 4'd0) holdoff_r <= holdoff_r - 4'd1;
    else                        holdoff_r <= holdoff_r;
  end

  // Statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge pcie_clk) begin
    if (pcie_reset || stat_clear) begin
      np_pkts_r     <= 32'd0;
      p_pkts_r      <= 32'd0;
      gate_cycles_r <= 32'd0;
    end else begin
      if (np_sop_accept_s)                 np_pkts_r     <= np_pkts_r + 32'd1;
      if (sop_accept_s && sop_posted_s)    p_pkts_r      <= p_pkts_r + 32'd1;
      if (gate_block_s)                    gate_cycles_r <= gate_cycles_r + 32'd1;
    end
  end

  assign in_rq_tready     = in_ready_s;
  assign out_rq_tvalid    = out_valid_r;
  assign {out_rq_tdata, out_rq_tuser, out_rq_tkeep, out_rq_tlast} = head_r;
  assign stat_np_pkts     = np_pkts_r;
  assign stat_p_pkts      = p_pkts_r;
  assign stat_gate_cycles = gate_cycles_r;

endmodule

// File: tb/tb_pcie_rq_np_gate.sv
// Scoreboard bench for pcie_rq_np_gate: directed packets push expected beats,
// a negedge monitor pops and compares every output transfer.
module tb_pcie_rq_np_gate;

  logic         clk = 1'b0;
  logic         pcie_reset;
  logic [255:0] in_rq_tdata;
  logic [59:0]  in_rq_tuser;
  logic [7:0]   in_rq_tkeep;
  logic         in_rq_tlast, in_rq_tvalid, in_rq_tready;
  logic [255:0] out_rq_tdata;
  logic [59:0]  out_rq_tuser;
  logic [7:0]   out_rq_tkeep;
  logic         out_rq_tlast, out_rq_tvalid, out_rq_tready;
  logic [1:0]   nph_av, npd_av;
  logic         stat_clear;
  logic [31:0]  stat_np_pkts, stat_p_pkts, stat_gate_cycles;

  pcie_rq_np_gate dut (
    .pcie_clk(clk), .pcie_reset(pcie_reset),
    .in_rq_tdata(in_rq_tdata), .in_rq_tuser(in_rq_tuser), .in_rq_tkeep(in_rq_tkeep),
    .in_rq_tlast(in_rq_tlast), .in_rq_tvalid(in_rq_tvalid), .in_rq_tready(in_rq_tready),
    .out_rq_tdata(out_rq_tdata), .out_rq_tuser(out_rq_tuser), .out_rq_tkeep(out_rq_tkeep),
    .out_rq_tlast(out_rq_tlast), .out_rq_tvalid(out_rq_tvalid), .out_rq_tready(out_rq_tready),
    .pcie_tfc_nph_av(nph_av), .pcie_tfc_npd_av(npd_av), .stat_clear(stat_clear),
    .stat_np_pkts(stat_np_pkts), .stat_p_pkts(stat_p_pkts), .stat_gate_cycles(stat_gate_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc, sop_cyc, acc_beats;
  logic [324:0] exp_q[$];
  int pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer is compared against the scoreboard head
  always @(negedge clk) begin
    logic [324:0] got, e;
    if (out_rq_tvalid === 1'b1 && out_rq_tready === 1'b1) begin
      got = {out_rq_tdata, out_rq_tuser, out_rq_tkeep, out_rq_tlast};
      pop_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got %0h expected %0h", got, e);
        end
      end
    end
  end

  function automatic logic [324:0] mk_beat(input int tag, input int b, input logic [3:0] typ, input bit last);
    logic [255:0] d;
    logic [59:0]  u;
    logic [7:0]   k;
    d = {8{tag[15:0], b[15:0]}};
    d[78:75] = typ;
    u = {tag[15:0], b[15:0], 28'h5A5A5A5};
    k = 8'hFF >> b[2:0];
    return {d, u, k, last};
  endfunction

  task automatic drive_beat(input logic [324:0] beat, input int max_wait, output bit ok);
    {in_rq_tdata, in_rq_tuser, in_rq_tkeep, in_rq_tlast} = beat;
    in_rq_tvalid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < max_wait && !ok; w++) begin
      @(negedge clk);
      if (in_rq_tready === 1'b1) begin
        ok = 1'b1;
        acc_cyc = cyc;
        acc_beats++;
      end
      @(posedge clk);
      #1;
      stat_clear = 1'b0;
    end
  endtask

  task automatic send_pkt(input int tag, input logic [3:0] typ, input int n, input bit expect_pass, input bit drop_npd);
    logic [324:0] beat;
    bit ok;
    for (int b = 0; b < n; b++) begin
      beat = mk_beat(tag, b, typ, b == n - 1);
      if (expect_pass) exp_q.push_back(beat);
      drive_beat(beat, expect_pass ? 100 : 10, ok);
      chk(expect_pass ? "accept" : "blocked", {63'd0, ok}, {63'd0, expect_pass});
      if (b == 0) sop_cyc = acc_cyc;
      if (b == 0 && drop_npd) npd_av = 2'd0;
      if (!ok) break;
    end
    in_rq_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_contig(input int n);
    chk("pop_count", pop_cyc.size(), n);
    for (int i = 1; i < pop_cyc.size(); i++) chk("contig", pop_cyc[i] - pop_cyc[i-1], 1);
  endtask

  initial begin
    int c0, g0;
    bit ok;
    pcie_reset = 1'b1; in_rq_tdata = '0; in_rq_tuser = '0; in_rq_tkeep = '0;
    in_rq_tlast = 1'b0; in_rq_tvalid = 1'b0; out_rq_tready = 1'b1;
    nph_av = 2'd3; npd_av = 2'd3; stat_clear = 1'b0; acc_beats = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", {63'd0, in_rq_tready}, 64'd0);
    @(posedge clk); #1;
    pcie_reset = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", {63'd0, out_rq_tvalid}, 64'd0);
    chk("rst_tdata", out_rq_tdata[63:0], 64'd0);
    chk("rst_tuser", {4'd0, out_rq_tuser}, 64'd0);
    chk("rst_tlast", {63'd0, out_rq_tlast}, 64'd0);
    chk("rst_stats", {stat_np_pkts, stat_p_pkts | stat_gate_cycles}, 64'd0);
    chk("ready_after_reset", {63'd0, in_rq_tready}, 64'd1);
    @(posedge clk); #1;

    // Back-to-back MemRd with hold-off
    send_pkt(1, 4'b0000, 1, 1'b1, 1'b0);
    c0 = sop_cyc;
    send_pkt(2, 4'b0000, 1, 1'b1, 1'b0);
    chk("holdoff_gap", sop_cyc - c0, 5);
    @(negedge clk);
    chk("gate_cycles", stat_gate_cycles, 4);
    chk("np_pkts", stat_np_pkts, 2);
    wait_drain();

    // Posted MemWr with zero NP credit
    pop_cyc.delete();
    nph_av = 2'd0; npd_av = 2'd0;
    send_pkt(3, 4'b0001, 3, 1'b1, 1'b0);
    wait_drain();
    chk_contig(3);
    if (pop_cyc.size() > 0) chk("latency", pop_cyc[0] - sop_cyc, 1);
    chk("p_pkts", stat_p_pkts, 1);

    // IOWr with data credit dropping after SOP, then an IOWr short of data credit
    pop_cyc.delete();
    nph_av = 2'd3; npd_av = 2'd3;
    send_pkt(5, 4'b0011, 4, 1'b1, 1'b1);
    wait_drain();
    chk_contig(4);
    npd_av = 2'd1;
    g0 = stat_gate_cycles;
    send_pkt(6, 4'b0011, 1, 1'b0, 1'b0);
    chk("gate_delta", stat_gate_cycles - g0, 10);
    chk("np_pkts2", stat_np_pkts, 3);

    // Backpressure during an 8-beat MemWr
    out_rq_tready = 1'b0;
    acc_beats = 0;
    fork
      send_pkt(7, 4'b0001, 8, 1'b1, 1'b0);
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", acc_beats, 2);
        chk("bp_ready", {63'd0, in_rq_tready}, 64'd0);
        @(posedge clk); #1;
        out_rq_tready = 1'b1;
      end
    join
    wait_drain();

    // Reset in the middle of a 4-beat packet
    exp_q.push_back(mk_beat(8, 0, 4'b0001, 1'b0));
    drive_beat(mk_beat(8, 0, 4'b0001, 1'b0), 100, ok);
    chk("mid_sop", {63'd0, ok}, 64'd1);
    {in_rq_tdata, in_rq_tuser, in_rq_tkeep, in_rq_tlast} = mk_beat(8, 1, 4'b0001, 1'b0);
    pcie_reset = 1'b1;
    @(negedge clk);
    chk("mid_ready", {63'd0, in_rq_tready}, 64'd0);
    @(posedge clk); #1;
    pcie_reset = 1'b0;
    in_rq_tvalid = 1'b0;
    @(negedge clk);
    chk("mid_tvalid", {63'd0, out_rq_tvalid}, 64'd0);
    chk("mid_tdata", out_rq_tdata[63:0], 64'd0);
    chk("mid_stats", {stat_np_pkts, stat_p_pkts | stat_gate_cycles}, 64'd0);
    @(posedge clk); #1;
    nph_av = 2'd1;
    send_pkt(9, 4'b0000, 1, 1'b0, 1'b0);
    nph_av = 2'd2; npd_av = 2'd0;
    send_pkt(10, 4'b0000, 1, 1'b1, 1'b0);
    wait_drain();
    chk("np_after_reset", stat_np_pkts, 1);

    // Statistics clear coincident with a posted SOP
    for (int i = 0; i < 7; i++) send_pkt(11 + i, (i % 2 == 1) ? 4'b1101 : 4'b0001, 1, 1'b1, 1'b0);
    @(negedge clk);
    chk("p_pkts7", stat_p_pkts, 7);
    @(posedge clk); #1;
    stat_clear = 1'b1;
    send_pkt(20, 4'b1100, 1, 1'b1, 1'b0);
    @(negedge clk);
    chk("clear_wins", stat_p_pkts, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
